// File: rtl/accel_spi_reader.sv
// accel_spi_reader: SPI master (mode 3) for the ADXL345 accelerometer.
// After reset it writes DATA_FORMAT and POWER_CTL. After that it burst-reads
// X/Y once per SAMPLE_PERIOD and presents 8-bit signed tilt values in the
// pixel_clk domain.
// Optional feature: define ACCEL_AVG_EN to output the mean of the last four
// samples instead of the raw mapped sample.
module accel_spi_reader #(
    parameter int CLK_DIV       = 9,
    parameter int SAMPLE_PERIOD = 36000
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic signed [7:0] accel_data_x,
    output logic signed [7:0] accel_data_y,
    output logic              data_valid
);

    localparam int         DIV_W    = $clog2(2 * CLK_DIV);
    localparam int         TMR_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [7:0] READ_CMD = 8'hF2;

    typedef enum logic [2:0] {
        S_CFG0,
        S_CFG1,
        S_IDLE,
        S_READ,
        S_GAP
    } state_t;

    state_t            state;
    state_t            gap_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [6:0]        edge_cnt;
    logic [6:0]        edge_end;
    logic              div_done;
    logic              gap_done;
    logic              timer_wrap;
    logic [39:0]       tx_shift;
    logic [31:0]       rx_shift;
    logic [TMR_W-1:0]  timer;
    logic              pending;
    logic              upd_p0;
    logic signed [7:0] x_raw;
    logic signed [7:0] y_raw;

    // A transaction has 2*bits SCLK edges, then one more half-period of hold.
    assign div_done   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign gap_done   = (div_cnt == DIV_W'(2 * CLK_DIV - 2));
    assign timer_wrap = (timer == TMR_W'(SAMPLE_PERIOD - 1));
    assign edge_end   = (state == S_READ) ? 7'd80 : 7'd32;

    // Captured bytes arrive as X0, X1, Y0, Y1. Each tilt value is bits [9:2]
    // of the 10-bit reading, so only the low two bits of X1/Y1 are used.
    assign x_raw = {rx_shift[17:16], rx_shift[31:26]};
    assign y_raw = {rx_shift[1:0],   rx_shift[15:10]};

    // Free-running sample timer; it also runs while configuration is in progress.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (timer_wrap) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Transaction sequencer and SPI shifter; all SPI pins are registered.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state    <= S_CFG0;
            gap_next <= S_CFG1;
            spi_sclk <= 1'b1;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            pending  <= 1'b0;
            upd_p0   <= 1'b0;
        end else begin
            upd_p0 <= 1'b0;
            if (timer_wrap) begin
                pending <= 1'b1;
            end
            case (state)
                S_CFG0, S_CFG1, S_READ: begin
                    if (spi_cs_n) begin
                        // The first cycle in a transaction state asserts chip select.
                        spi_cs_n <= 1'b0;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        tx_shift <= (state == S_READ) ? {READ_CMD, 32'h0} :
                                    (state == S_CFG0) ? {8'h31, 8'h00, 24'h0} :
                                                        {8'h2D, 8'h08, 24'h0};
                    end else if (div_done) begin
                        div_cnt  <= '0;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (edge_cnt == edge_end) begin
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                            state    <= S_GAP;
                            gap_next <= (state == S_CFG0) ? S_CFG1 : S_IDLE;
                            upd_p0   <= (state == S_READ);
                        end else if (!edge_cnt[0]) begin
                            spi_sclk <= 1'b0;
                            spi_mosi <= tx_shift[39];
                            tx_shift <= {tx_shift[38:0], 1'b0};
                        end else begin
                            spi_sclk <= 1'b1;
                            rx_shift <= {rx_shift[30:0], spi_miso};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        div_cnt <= '0;
                        state   <= gap_next;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (pending) begin
                        state <= S_READ;
                        // A wrap that coincides with the start of a read stays pending.
                        if (!timer_wrap) begin
                            pending <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_CFG0;
                end
            endcase
        end
    end

`ifdef ACCEL_AVG_EN
    logic signed [7:0] hist_x [3];
    logic signed [7:0] hist_y [3];

    // Mean of four samples, floored (arithmetic shift right by two).
    function automatic logic signed [7:0] avg4(input logic signed [7:0] a,
                                               input logic signed [7:0] b,
                                               input logic signed [7:0] c,
                                               input logic signed [7:0] d);
        logic signed [9:0] sum;
        sum = 10'(a) + 10'(b) + 10'(c) + 10'(d);
        return sum[9:2];
    endfunction

    // Output stage: average the new sample with the three previous samples.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            accel_data_x <= '0;
            accel_data_y <= '0;
            data_valid   <= 1'b0;
            hist_x[0]    <= '0;
            hist_x[1]    <= '0;
            hist_x[2]    <= '0;
            hist_y[0]    <= '0;
            hist_y[1]    <= '0;
            hist_y[2]    <= '0;
        end else begin
            data_valid <= upd_p0;
            if (upd_p0) begin
                accel_data_x <= avg4(x_raw, hist_x[0], hist_x[1], hist_x[2]);
                accel_data_y <= avg4(y_raw, hist_y[0], hist_y[1], hist_y[2]);
                hist_x[0]    <= x_raw;
                hist_x[1]    <= hist_x[0];
                hist_x[2]    <= hist_x[1];
                hist_y[0]    <= y_raw;
                hist_y[1]    <= hist_y[0];
                hist_y[2]    <= hist_y[1];
            end
        end
    end
`else
    // Output stage: register the raw mapped sample one cycle after cs_n rises.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            accel_data_x <= '0;
            accel_data_y <= '0;
            data_valid   <= 1'b0;
        end else begin
            data_valid <= upd_p0;
            if (upd_p0) begin
                accel_data_x <= x_raw;
                accel_data_y <= y_raw;
            end
        end
    end
`endif

endmodule

// File: tb/tb_accel_spi_reader.sv
// Testbench for accel_spi_reader. It contains an SPI slave model, a line
// monitor and a scoreboard of expected tilt values.
module tb_accel_spi_reader;

    localparam int CLK_DIV       = 9;
    localparam int SAMPLE_PERIOD = 2000;

    logic       pixel_clk = 1'b0;
    logic       rst_n     = 1'b0;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso  = 1'b0;
    logic [7:0] accel_data_x;
    logic [7:0] accel_data_y;
    logic       data_valid;

    accel_spi_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) dut (
        .pixel_clk    (pixel_clk),
        .rst_n        (rst_n),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .accel_data_x (accel_data_x),
        .accel_data_y (accel_data_y),
        .data_valid   (data_valid)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [39:0] bits;
        int          nbits;
        int          fall_cyc;
        int          rise_cyc;
    } frame_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
    } exp_t;

    frame_t      frames[$];
    exp_t        exp_q[$];
    int          n_cmp    = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          dv_count = 0;
    logic [31:0] next_resp = 32'h0;
    logic [31:0] s_resp   = 32'h0;
    logic [39:0] s_out    = 40'h0;
    logic [39:0] s_bits   = 40'h0;
    int          s_cnt    = 0;
    bit          mon_en   = 1'b0;
    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b1;
    int          fall_cyc  = 0;
    int          rise_cyc  = 0;
    int          last_rise = 0;
    bit          have_rise = 1'b0;
    bit          first_fall_pend = 1'b0;
    int          hx[3];
    int          hy[3];
    frame_t      mon_f;
    exp_t        mon_e;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    // Reference tilt mapping: bits [9:2] of {hi[1:0], lo}.
    function automatic logic [7:0] model_map(input logic [7:0] lo, input logic [7:0] hi);
        logic [9:0] v;
        v = {hi[1:0], lo};
        return v[9:2];
    endfunction

    task automatic model_push(input logic [31:0] r);
        exp_t       e;
        logic [7:0] xr;
        logic [7:0] yr;
        xr = model_map(r[31:24], r[23:16]);
        yr = model_map(r[15:8], r[7:0]);
`ifdef ACCEL_AVG_EN
        begin
            int sx;
            int sy;
            sx = $signed(xr) + hx[0] + hx[1] + hx[2];
            sy = $signed(yr) + hy[0] + hy[1] + hy[2];
            e.x = 8'(sx >>> 2);
            e.y = 8'(sy >>> 2);
            hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = $signed(xr);
            hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = $signed(yr);
        end
`else
        e.x = xr;
        e.y = yr;
`endif
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            hx[i] = 0;
            hy[i] = 0;
        end
        exp_q.delete();
    endtask

    // SPI slave: load the response at cs_n fall, drive MISO on SCLK fall, sample MOSI on SCLK rise.
    always @(negedge spi_cs_n) begin
        s_bits = 40'h0;
        s_cnt  = 0;
        s_resp = next_resp;
        s_out  = {8'h00, next_resp};
    end

    always @(negedge spi_sclk) begin
        if (spi_cs_n === 1'b0) begin
            spi_miso = s_out[39];
            s_out    = {s_out[38:0], 1'b0};
        end
    end

    always @(posedge spi_sclk) begin
        if (spi_cs_n === 1'b0) begin
            s_bits = {s_bits[38:0], spi_mosi};
            s_cnt  = s_cnt + 1;
        end
    end

    // Line monitor and scoreboard consumer, sampled on the falling pixel_clk edge.
    always @(negedge pixel_clk) begin
        if (mon_en) begin
            if (spi_cs_n === 1'b1) begin
                n_cmp++;
                if (spi_sclk !== 1'b1 || spi_mosi !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_lines: sclk=%b mosi=%b, required sclk=1 mosi=0 (cycle %0d)",
                             spi_sclk, spi_mosi, cyc);
                end
            end
            if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
                fall_cyc        = cyc;
                have_rise       = 1'b0;
                first_fall_pend = 1'b1;
            end
            if (spi_cs_n === 1'b0 && prev_sclk === 1'b1 && spi_sclk === 1'b0 && first_fall_pend) begin
                first_fall_pend = 1'b0;
                n_cmp++;
                if (cyc - fall_cyc != CLK_DIV) begin
                    n_fail++;
                    $display("FAIL first_sclk_fall: %0d cycles after cs_n fall, required %0d",
                             cyc - fall_cyc, CLK_DIV);
                end
            end
            if (spi_cs_n === 1'b0 && prev_sclk === 1'b0 && spi_sclk === 1'b1) begin
                if (have_rise) begin
                    n_cmp++;
                    if (cyc - last_rise != 2 * CLK_DIV) begin
                        n_fail++;
                        $display("FAIL sclk_period: %0d cycles, required %0d",
                                 cyc - last_rise, 2 * CLK_DIV);
                    end
                end
                have_rise = 1'b1;
                last_rise = cyc;
            end
            if (prev_cs === 1'b0 && spi_cs_n === 1'b1) begin
                rise_cyc       = cyc;
                mon_f.bits     = s_bits;
                mon_f.nbits    = s_cnt;
                mon_f.fall_cyc = fall_cyc;
                mon_f.rise_cyc = cyc;
                frames.push_back(mon_f);
                if (s_cnt == 40) model_push(s_resp);
            end
            if (data_valid === 1'b1) begin
                dv_count++;
                n_cmp++;
                if (cyc - rise_cyc != 1) begin
                    n_fail++;
                    $display("FAIL dv_timing: data_valid %0d cycles after cs_n rise, required 1",
                             cyc - rise_cyc);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dv_unexpected: data_valid with x=%h y=%h, required no pulse",
                             accel_data_x, accel_data_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (accel_data_x !== mon_e.x || accel_data_y !== mon_e.y) begin
                        n_fail++;
                        $display("FAIL sample_value: x=%h y=%h, required x=%h y=%h",
                                 accel_data_x, accel_data_y, mon_e.x, mon_e.y);
                    end
                end
            end
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    task automatic wait_frame(output frame_t f, output bit ok);
        int t;
        t  = 0;
        ok = 1'b0;
        f.bits = 40'h0; f.nbits = 0; f.fall_cyc = 0; f.rise_cyc = 0;
        while (frames.size() == 0 && t < 5000) begin
            @(negedge pixel_clk);
            t++;
        end
        if (frames.size() > 0) begin
            f  = frames.pop_front();
            ok = 1'b1;
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_timeout: no frame within %0d cycles, required one", t);
        end
    endtask

    task automatic wait_read(output frame_t f, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        f.bits = 40'h0; f.nbits = 0; f.fall_cyc = 0; f.rise_cyc = 0;
        while (!ok && n < 4) begin
            wait_frame(f, ok);
            if (ok && f.nbits != 40) ok = 1'b0;
            n++;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL read_timeout: no 40-bit frame seen, required one");
        end
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        rst_n = 1'b0;
        repeat (3) @(negedge pixel_clk);
        model_clear();
        frames.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        n_cmp++; if (spi_sclk !== 1'b1) begin n_fail++; $display("FAIL rst_sclk: %b, required 1", spi_sclk); end
        n_cmp++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: %b, required 1", spi_cs_n); end
        n_cmp++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: %b, required 0", spi_mosi); end
        n_cmp++; if (accel_data_x !== 8'h00) begin n_fail++; $display("FAIL rst_x: %h, required 00", accel_data_x); end
        n_cmp++; if (accel_data_y !== 8'h00) begin n_fail++; $display("FAIL rst_y: %h, required 00", accel_data_y); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dv: %b, required 0", data_valid); end
        model_clear();
        frames.delete();
        mon_en = 1'b1;
        rst_n  = 1'b1;
    endtask

    task automatic test_config();
        frame_t f0;
        frame_t f1;
        bit     ok0;
        bit     ok1;
        wait_frame(f0, ok0);
        wait_frame(f1, ok1);
        if (ok0) begin
            n_cmp++;
            if (f0.nbits != 16 || f0.bits[15:0] !== 16'h3100) begin
                n_fail++;
                $display("FAIL cfg0_frame: %0d bits %h, required 16 bits 3100", f0.nbits, f0.bits[15:0]);
            end
            n_cmp++;
            if (f0.rise_cyc - f0.fall_cyc != CLK_DIV * 33) begin
                n_fail++;
                $display("FAIL cfg0_cs_low: %0d cycles, required %0d", f0.rise_cyc - f0.fall_cyc, CLK_DIV * 33);
            end
        end
        if (ok1) begin
            n_cmp++;
            if (f1.nbits != 16 || f1.bits[15:0] !== 16'h2D08) begin
                n_fail++;
                $display("FAIL cfg1_frame: %0d bits %h, required 16 bits 2d08", f1.nbits, f1.bits[15:0]);
            end
        end
        if (ok0 && ok1) begin
            n_cmp++;
            if (f1.fall_cyc - f0.rise_cyc < 2 * CLK_DIV) begin
                n_fail++;
                $display("FAIL cfg_gap: cs_n high %0d cycles, required >= %0d",
                         f1.fall_cyc - f0.rise_cyc, 2 * CLK_DIV);
            end
        end
    endtask

    task automatic test_read();
        frame_t f;
        bit     ok;
        int     dv0;
        next_resp = 32'h4000C003;
        dv0 = dv_count;
        wait_read(f, ok);
        if (ok) begin
            n_cmp++;
            if (f.bits[39:32] !== 8'hF2) begin
                n_fail++;
                $display("FAIL read_cmd: %h, required f2", f.bits[39:32]);
            end
            n_cmp++;
            if (f.rise_cyc - f.fall_cyc != CLK_DIV * 81) begin
                n_fail++;
                $display("FAIL read_cs_low: %0d cycles, required %0d", f.rise_cyc - f.fall_cyc, CLK_DIV * 81);
            end
        end
        repeat (3) @(negedge pixel_clk);
        n_cmp++;
        if (dv_count - dv0 != 1) begin
            n_fail++;
            $display("FAIL read_dv_count: %0d pulses, required 1", dv_count - dv0);
        end
`ifdef ACCEL_AVG_EN
        n_cmp++; if (accel_data_x !== 8'h04) begin n_fail++; $display("FAIL read_x: %h, required 04", accel_data_x); end
        n_cmp++; if (accel_data_y !== 8'hFC) begin n_fail++; $display("FAIL read_y: %h, required fc", accel_data_y); end
`else
        n_cmp++; if (accel_data_x !== 8'h10) begin n_fail++; $display("FAIL read_x: %h, required 10", accel_data_x); end
        n_cmp++; if (accel_data_y !== 8'hF0) begin n_fail++; $display("FAIL read_y: %h, required f0", accel_data_y); end
`endif
    endtask

    task automatic test_period();
        frame_t f;
        bit     ok;
        int     falls[3];
        bit     oks[3];
        int     dv0;
        frames.delete();
        dv0 = dv_count;
        next_resp = $urandom;
        for (int i = 0; i < 3; i++) begin
            wait_read(f, ok);
            oks[i]   = ok;
            falls[i] = f.fall_cyc;
            next_resp = $urandom;
        end
        for (int i = 1; i < 3; i++) begin
            if (oks[i] && oks[i-1]) begin
                n_cmp++;
                if (falls[i] - falls[i-1] != SAMPLE_PERIOD) begin
                    n_fail++;
                    $display("FAIL read_period: %0d cycles, required %0d", falls[i] - falls[i-1], SAMPLE_PERIOD);
                end
            end
        end
        repeat (3) @(negedge pixel_clk);
        n_cmp++;
        if (dv_count - dv0 != 3) begin
            n_fail++;
            $display("FAIL period_dv_count: %0d pulses, required 3", dv_count - dv0);
        end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        bit     ok;
        int     t;
        int     nf;
        int     dv0;
        logic   ps;
        frames.delete();
        next_resp = 32'h7F01_8002;
        t = 0;
        while (spi_cs_n !== 1'b0 && t < 4000) begin
            @(negedge pixel_clk);
            t++;
        end
        nf = 0;
        ps = spi_sclk;
        while (nf < 20 && t < 6000) begin
            @(negedge pixel_clk);
            if (ps === 1'b1 && spi_sclk === 1'b0) nf++;
            ps = spi_sclk;
            t++;
        end
        n_cmp++;
        if (nf != 20) begin
            n_fail++;
            $display("FAIL mid_wait: saw %0d SCLK falls, required 20", nf);
        end
        repeat (4) @(negedge pixel_clk);
        dv0   = dv_count;
        rst_n = 1'b0;
        @(negedge pixel_clk);
        n_cmp++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL mid_cs_n: %b, required 1", spi_cs_n); end
        n_cmp++; if (spi_sclk !== 1'b1) begin n_fail++; $display("FAIL mid_sclk: %b, required 1", spi_sclk); end
        n_cmp++; if (accel_data_x !== 8'h00 || accel_data_y !== 8'h00) begin
            n_fail++; $display("FAIL mid_xy: x=%h y=%h, required 00 00", accel_data_x, accel_data_y);
        end
        model_clear();
        repeat (3) @(negedge pixel_clk);
        rst_n = 1'b1;
        wait_frame(f, ok);
        if (ok) begin
            n_cmp++;
            if (f.nbits >= 40) begin
                n_fail++;
                $display("FAIL mid_abort: aborted frame had %0d bits, required < 40", f.nbits);
            end
        end
        wait_frame(f, ok);
        if (ok) begin
            n_cmp++;
            if (f.nbits != 16 || f.bits[15:0] !== 16'h3100) begin
                n_fail++;
                $display("FAIL mid_recfg: %0d bits %h, required 16 bits 3100", f.nbits, f.bits[15:0]);
            end
        end
        n_cmp++;
        if (dv_count != dv0) begin
            n_fail++;
            $display("FAIL mid_stale: %0d pulses after reset, required 0", dv_count - dv0);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] resp[8];
        logic [7:0]  expx[8];
        frame_t      f;
        bit          ok;
        resp = '{32'h40FC0000, 32'h80000000, 32'hC0000000, 32'h00010000,
                 32'hF0030000, 32'hF0AB0000, 32'hF0030000, 32'hF0030000};
`ifdef ACCEL_AVG_EN
        expx = '{8'h04, 8'h0C, 8'h18, 8'h28, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
`else
        expx = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hFC, 8'hFC, 8'hFC, 8'hFC};
`endif
        for (int k = 0; k < 8; k++) begin
            if (k == 0 || k == 4) begin
                next_resp = resp[k];
                do_reset();
            end
            next_resp = resp[k];
            wait_read(f, ok);
            repeat (2) @(negedge pixel_clk);
            n_cmp++;
            if (accel_data_x !== expx[k] || accel_data_y !== 8'h00) begin
                n_fail++;
                $display("FAIL seq_x[%0d]: x=%h y=%h, required x=%h y=00",
                         k, accel_data_x, accel_data_y, expx[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_read();
        test_period();
        test_reset_mid();
        test_sequence();
        repeat (4) @(negedge pixel_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded 90000 cycles, required completion");
        $fatal(1, "watchdog");
    end

endmodule
